agit_ctrl: RTL and testbench
============================

# agit_ctrl

Heater and stirrer-motor controller for the agitator. Takes the user's temperature and speed modes from the mode counter, plus the filtered PT100 temperature, and drives the `heater_o` and `motor_o` pins. Heater control is a bang-bang thermostat with hysteresis. The motor is driven by PWM with a soft-start/soft-stop duty ramp. An over-temperature and sensor-watchdog supervisor forces a safe state on fault.

## Interface
- `PWM_BITS`, default 8: PWM counter and duty width; PWM period is 2^PWM_BITS clocks.
- `RAMP_DIV`, default 390625: clocks per one-LSB duty step (≈1 s full ramp at 100 MHz).
- `HYST`, default 2: thermostat hysteresis in °C.
- `T_MAX`, default 120: over-temperature fault threshold in °C.
- `TEMP_TIMEOUT`, default 50000000: watchdog limit, in clocks, without a `temp_valid_i` pulse.
- `clk_i` input 1: system clock, 100 MHz.
- `rst_i` input 1: asynchronous, active-high reset.
- `tempMode_i` input 4: 0 = heater off; 1..9 = setpoint 20+10·mode °C; values >9 clamp to 9 (110 °C).
- `velMode_i` input 4: 0 = motor off; 1..9 = target duty mode·28; values >9 clamp to 9 (252).
- `temp_i` input 8: filtered temperature in °C, unsigned.
- `temp_valid_i` input 1: single-cycle pulse, synchronous to `clk_i`, marking a new `temp_i` sample.
- `heater_o` output 1: heater enable, registered.
- `motor_o` output 1: motor PWM, registered.
- `state_o` output 2: FSM state; IDLE=0, RUN=1, STOP=2, FAULT=3.
- `fault_o` output 1: high while in FAULT.

## Operation
- **FSM, IDLE**
  - Heater is 0 and duty is 0.
  - Goes to RUN when `tempMode_i`≠0 or `velMode_i`≠0.
- **FSM, RUN**
  - Thermostat and motor ramp are active.
  - Goes to STOP when both modes are 0.
- **FSM, STOP**
  - Heater is 0 and duty ramps toward 0.
  - Goes to IDLE when duty==0.
  - Goes back to RUN if either mode becomes nonzero.
- **FSM, FAULT**
  - Heater is forced 0 and duty ramps toward 0.
  - Goes to IDLE only when all of the following hold: both modes are 0, duty==0, and the last valid sample was < T_MAX−HYST.
- **Fault entry**
  - Entered from any state on a `temp_valid_i` pulse with `temp_i` ≥ T_MAX.
  - Also entered on watchdog expiry; see Configuration.
  - Fault entry has priority over every other transition in the same cycle.
- **Thermostat**
  - Evaluated only in RUN, and only on a `temp_valid_i` pulse.
  - `temp_i` ≤ sp−HYST → heater 1.
  - `temp_i` ≥ sp → heater 0.
  - Otherwise heater holds its value.
  - With `tempMode_i`=0, heater is 0.
  - Setpoint arithmetic is 8-bit unsigned; sp−HYST cannot underflow because sp ≥ 30.
- **Ramp**
  - A prescaler counts 0..RAMP_DIV−1. On wrap, duty moves one LSB toward the target, or holds if equal.
  - Target is mode·28 in RUN and 0 in STOP, FAULT and IDLE.
  - A target change mid-ramp takes effect on the next step; no restart.
- **PWM**
  - Free-running counter `cnt` of width PWM_BITS.
  - `motor_o` <= (`cnt` < duty). Duty 0 gives constant 0; maximum duty 252 gives 252/256 high time.
- **Watchdog**
  - Counter is cleared by every `temp_valid_i` pulse.
  - Saturates at TEMP_TIMEOUT.

## Timing
- **Reset:** async assertion sets `heater_o`=0, `motor_o`=0, `state_o`=0, `fault_o`=0. Duty, PWM counter, prescaler and watchdog are cleared. Release is synchronous to the next `clk_i` edge.
- **Heater latency:** `heater_o` changes 1 clock after the qualifying `temp_valid_i` cycle.
- **FSM latency:** `state_o` and `fault_o` update 1 clock after the triggering condition. A fault clears `heater_o` in that same clock.
- **PWM latency:** `motor_o` lags the compare by 1 clock. A new duty value applies from the next `cnt` value; no glitch-free period alignment is required.
- **Ramp timing:** full 0→252 takes 252·RAMP_DIV clocks, ±RAMP_DIV.
- **Simultaneous events:** a `temp_valid_i` pulse in the same cycle as watchdog expiry counts as a sample; the watchdog does not fire.

## Configuration
- `AGIT_WATCHDOG_EN` defined: the watchdog counter is built. Reaching TEMP_TIMEOUT with no pulse enters FAULT, and the FAULT exit additionally requires a valid sample after entry.
- `AGIT_WATCHDOG_EN` undefined: no watchdog logic. FAULT is entered only on over-temperature.

## Test plan
Bench parameters: RAMP_DIV=4, TEMP_TIMEOUT=1000, `AGIT_WATCHDOG_EN` defined.
- **Reset:** assert `rst_i` mid-RUN with duty=100 and heater on → `heater_o`, `motor_o`, `state_o` and `fault_o` all 0 immediately, without waiting for a clock edge.
- **Thermostat:** `tempMode_i`=3 (sp 50); pulse samples 47, 48, 49, 50, 48 → heater 0, 1, 1, 0, 1, each 1 clock after its pulse.
- **Ramp:** `velMode_i` 0→5 → duty reaches 140 after 560±4 clocks; `motor_o` is high 140 of 256 cycles. Then set mode 0 → STOP, then IDLE when duty hits 0.
- **Over-temperature:** in RUN with heater on, pulse `temp_i`=120 → `fault_o`=1 and `heater_o`=0 next clock, duty ramps to 0. Modes set to 0 plus sample 100 → IDLE.
- **Watchdog:** no `temp_valid_i` for 1000 clocks in RUN → FAULT. A pulse exactly at clock 1000 → no fault.
- **Clamp and priority:** `velMode_i`=15 → duty target 252. A pulse with 125 in the same cycle that modes go to 0 → FAULT, not STOP.

Source files
------------

// File: rtl/agit_ctrl_if.sv
// ---------------------------------------------------------------------------
// agit_ctrl_if
// Bundles the agitator controller's mode, sensor and actuator signals.
//   tempMode_i   [3:0]  temperature mode (0 = heater off, 1..9, >9 clamps)
//   velMode_i    [3:0]  stirrer speed mode (0 = motor off, 1..9, >9 clamps)
//   temp_i       [7:0]  filtered PT100 temperature, degrees C
//   temp_valid_i        single-cycle strobe marking a new temp_i sample
//   heater_o            heater enable
//   motor_o             stirrer motor PWM
//   state_o      [1:0]  controller state (IDLE/RUN/STOP/FAULT)
//   fault_o             high while the controller is in FAULT
// The master modport belongs to whoever drives modes and samples; the slave
// modport belongs to the controller itself.
// ---------------------------------------------------------------------------
interface agit_ctrl_if;
   logic [3:0] tempMode_i;
   logic [3:0] velMode_i;
   logic [7:0] temp_i;
   logic       temp_valid_i;
   logic       heater_o;
   logic       motor_o;
   logic [1:0] state_o;
   logic       fault_o;

   modport master (
      output tempMode_i, velMode_i, temp_i, temp_valid_i,
      input  heater_o, motor_o, state_o, fault_o
   );

   modport slave (
      input  tempMode_i, velMode_i, temp_i, temp_valid_i,
      output heater_o, motor_o, state_o, fault_o
   );
endinterface

// File: rtl/agit_ctrl.sv
// ---------------------------------------------------------------------------
// agit_ctrl
// Heater and stirrer-motor controller for the agitator.
//   - bang-bang thermostat with hysteresis drives heater_o
//   - PWM motor drive with a soft-start/soft-stop duty ramp drives motor_o
//   - over-temperature supervisor (and optional sensor watchdog) forces a
//     safe FAULT state: heater off, duty ramping to zero
// Ports:
//   clk_i   system clock (100 MHz nominal)
//   rst_i   asynchronous, active-high reset
//   bus     agit_ctrl_if.slave (modes, temperature sample, heater/motor,
//           state and fault outputs)
// Optional build macro:
//   AGIT_WATCHDOG_EN  builds the sensor watchdog; TEMP_TIMEOUT clocks with
//                     no temp_valid_i pulse enters FAULT, and leaving FAULT
//                     also needs a fresh sample taken after the fault.
// ---------------------------------------------------------------------------
module agit_ctrl #(
   parameter int PWM_BITS     = 8,
   parameter int RAMP_DIV     = 390625,
   parameter int HYST         = 2,
   parameter int T_MAX        = 120,
   parameter int TEMP_TIMEOUT = 50000000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   agit_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STOP  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);
   localparam logic [7:0] T_MAX_8 = 8'(T_MAX);
   localparam logic [7:0] HYST_8  = 8'(HYST);
   localparam logic [7:0] COOL_8  = 8'(T_MAX - HYST);

   state_t              state_q;
   logic                heater_q;
   logic                motor_q;
   logic                lastCool_q;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] cnt_q;
   logic [PRE_W-1:0]    pre_q, pre_d;

   logic [3:0]          tModeClamped, vModeClamped;
   logic [7:0]          setpoint, velDuty;
   logic [PWM_BITS-1:0] dutyTarget;
   logic                anyMode, overTemp, faultReq, sampleOk;

   // Mode values above 9 behave like 9; setpoint is 20 + 10*mode degrees
   // and the motor target is 28 duty LSBs per speed step.
   assign tModeClamped = (bus.tempMode_i > 4'd9) ? 4'd9 : bus.tempMode_i;
   assign vModeClamped = (bus.velMode_i  > 4'd9) ? 4'd9 : bus.velMode_i;
   assign setpoint     = 8'd20 + (8'd10 * {4'd0, tModeClamped});
   assign velDuty      = 8'd28 * {4'd0, vModeClamped};
   assign anyMode      = (bus.tempMode_i != 4'd0) || (bus.velMode_i != 4'd0);
   assign overTemp     = bus.temp_valid_i && (bus.temp_i >= T_MAX_8);

`ifdef AGIT_WATCHDOG_EN
   localparam int WD_W = $clog2(TEMP_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TEMP_TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TEMP_TIMEOUT);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            sampled_q;
   logic            wdogFire;

   // The watchdog counts clocks since the last sample. It fires on the
   // clock that would be the TEMP_TIMEOUT-th without a pulse; a pulse in
   // that same clock counts as a sample, so it does not fire.
   assign wdogFire = !bus.temp_valid_i && (wdog_q >= WD_LAST);
   assign faultReq = overTemp || wdogFire;
   assign sampleOk = sampled_q;

   always_comb begin
      wdog_d = wdog_q;
      if (bus.temp_valid_i) begin
         wdog_d = '0;
      end else if (wdog_q != WD_MAX) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   // Watchdog register, plus a flag recording that a sample has arrived
   // since the most recent fault entry; FAULT may only be left once the
   // sensor has proven itself alive again.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wdog_q    <= '0;
         sampled_q <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         if (faultReq) begin
            sampled_q <= 1'b0;
         end else if (bus.temp_valid_i) begin
            sampled_q <= 1'b1;
         end
      end
   end
`else
   assign faultReq = overTemp;
   assign sampleOk = 1'b1;
`endif

   // The ramp only chases the speed setting while running; every other
   // state pulls the duty back to zero. A step is taken once per prescaler
   // wrap, so a target change mid-ramp simply redirects the next step.
   always_comb begin
      dutyTarget = (state_q == RUN) ? PWM_BITS'(velDuty) : '0;
      duty_d     = duty_q;
      pre_d      = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
      if (pre_q == PRE_LAST) begin
         if (duty_q < dutyTarget) begin
            duty_d = duty_q + 1'b1;
         end else if (duty_q > dutyTarget) begin
            duty_d = duty_q - 1'b1;
         end
      end
   end

   // Ramp prescaler, duty register and free-running PWM counter. The motor
   // pin is the registered compare, so it lags the counter by one clock.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pre_q   <= '0;
         duty_q  <= '0;
         cnt_q   <= '0;
         motor_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         duty_q  <= duty_d;
         cnt_q   <= cnt_q + 1'b1;
         motor_q <= (cnt_q < duty_q);
      end
   end

   // Controller FSM with the heater as a registered output. A fault request
   // overrides every other transition and drops the heater in the same
   // clock. The thermostat only acts in RUN on a sample strobe; between the
   // two thresholds the heater keeps its previous value (hysteresis).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         heater_q   <= 1'b0;
         lastCool_q <= 1'b1;
      end else begin
         if (bus.temp_valid_i) begin
            lastCool_q <= (bus.temp_i < COOL_8);
         end
         if (faultReq) begin
            state_q  <= FAULT;
            heater_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  heater_q <= 1'b0;
                  if (anyMode) begin
                     state_q <= RUN;
                  end
               end
               RUN: begin
                  if (tModeClamped == 4'd0) begin
                     heater_q <= 1'b0;
                  end else if (bus.temp_valid_i) begin
                     if (bus.temp_i <= (setpoint - HYST_8)) begin
                        heater_q <= 1'b1;
                     end else if (bus.temp_i >= setpoint) begin
                        heater_q <= 1'b0;
                     end
                  end
                  if (!anyMode) begin
                     state_q <= STOP;
                  end
               end
               STOP: begin
                  heater_q <= 1'b0;
                  if (anyMode) begin
                     state_q <= RUN;
                  end else if (duty_q == '0) begin
                     state_q <= IDLE;
                  end
               end
               FAULT: begin
                  heater_q <= 1'b0;
                  if (!anyMode && (duty_q == '0) && lastCool_q && sampleOk) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  heater_q <= 1'b0;
                  state_q  <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.heater_o = heater_q;
   assign bus.motor_o  = motor_q;
   assign bus.state_o  = state_q;
   assign bus.fault_o  = (state_q == FAULT);

endmodule

// File: tb/tb_agit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_agit_ctrl
// Drives agit_ctrl with directed scenarios and randomized mode/sample
// traffic. A behavioural model predicts heater, motor, state and fault for
// every clock; the driver queues the prediction and an independent monitor
// compares it with the DUT one time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_agit_ctrl;

   localparam int RAMP_DIV     = 4;
   localparam int TEMP_TIMEOUT = 1000;
   localparam int T_MAX        = 120;
   localparam int HYST         = 2;
   localparam int S_IDLE       = 0;
   localparam int S_RUN        = 1;
   localparam int S_STOP       = 2;
   localparam int S_FAULT      = 3;
`ifdef AGIT_WATCHDOG_EN
   localparam int WD_ON = 1;
`else
   localparam int WD_ON = 0;
`endif

   typedef struct {
      int heater;
      int motor;
      int state;
      int fault;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t expQ[$];

   // reference model state, all plain integers
   int mState, mHeater, mDuty, mCnt, mPre, mMiss, mMotor;
   bit mCool, mSeen;

   agit_ctrl_if bus();

   agit_ctrl #(
      .PWM_BITS     (8),
      .RAMP_DIV     (RAMP_DIV),
      .HYST         (HYST),
      .T_MAX        (T_MAX),
      .TEMP_TIMEOUT (TEMP_TIMEOUT)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mState  = S_IDLE;
      mHeater = 0;
      mDuty   = 0;
      mCnt    = 0;
      mPre    = 0;
      mMiss   = 0;
      mMotor  = 0;
      mCool   = 1'b1;
      mSeen   = 1'b0;
   endtask

   // Advances the model by one clock using the controller's rules and queues
   // the outputs expected after that clock.
   task automatic stepModel(input int tm0, input int vm0, input int tp, input bit v);
      int   tm, vm, sp, nState, nHeater, target;
      bit   wd, fault, anyMode;
      exp_t e;
      tm      = (tm0 > 9) ? 9 : tm0;
      vm      = (vm0 > 9) ? 9 : vm0;
      sp      = 20 + 10 * tm;
      anyMode = (tm0 != 0) || (vm0 != 0);
      wd      = (WD_ON != 0) && !v && (mMiss + 1 >= TEMP_TIMEOUT);
      fault   = (v && tp >= T_MAX) || wd;

      nState = mState;
      if (fault) nState = S_FAULT;
      else if (mState == S_IDLE) begin
         if (anyMode) nState = S_RUN;
      end else if (mState == S_RUN) begin
         if (!anyMode) nState = S_STOP;
      end else if (mState == S_STOP) begin
         if (anyMode) nState = S_RUN;
         else if (mDuty == 0) nState = S_IDLE;
      end else begin
         if (!anyMode && mDuty == 0 && mCool && (mSeen || WD_ON == 0)) nState = S_IDLE;
      end

      nHeater = mHeater;
      if (fault || mState != S_RUN || tm == 0) nHeater = 0;
      else if (v) begin
         if (tp <= sp - HYST) nHeater = 1;
         else if (tp >= sp) nHeater = 0;
      end

      mMotor = (mCnt < mDuty) ? 1 : 0;
      if (mPre == RAMP_DIV - 1) begin
         target = (mState == S_RUN) ? vm * 28 : 0;
         if (mDuty < target) mDuty++;
         else if (mDuty > target) mDuty--;
      end
      mCnt = (mCnt + 1) % 256;
      mPre = (mPre + 1) % RAMP_DIV;
      mMiss = v ? 0 : ((mMiss < TEMP_TIMEOUT) ? mMiss + 1 : mMiss);
      if (v) mCool = (tp < T_MAX - HYST);
      if (fault) mSeen = 1'b0;
      else if (v) mSeen = 1'b1;
      mState  = nState;
      mHeater = nHeater;

      e.heater = nHeater;
      e.motor  = mMotor;
      e.state  = nState;
      e.fault  = (nState == S_FAULT) ? 1 : 0;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input int tm, input int vm, input int tp, input bit v);
      @(negedge clk_i);
      bus.tempMode_i   = 4'(tm);
      bus.velMode_i    = 4'(vm);
      bus.temp_i       = 8'(tp);
      bus.temp_valid_i = v;
      stepModel(tm, vm, tp, v);
   endtask

   // Runs n clocks with fixed modes; pulses a sample every 'period' clocks
   // (never when period is 0) and counts motor_o high cycles.
   task automatic runCycles(input int n, input int tm, input int vm, input int tp,
                            input int period, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         applyStimulus(tm, vm, tp, (period > 0) && (i % period == period - 1));
         @(posedge clk_i);
         #2;
         highs += int'(bus.motor_o);
      end
   endtask

   task automatic releaseReset();
      @(negedge clk_i);
      rst_i            = 1'b0;
      bus.tempMode_i   = 4'd0;
      bus.velMode_i    = 4'd0;
      bus.temp_i       = 8'd0;
      bus.temp_valid_i = 1'b0;
      expQ.delete();
      modelReset();
      stepModel(0, 0, 0, 1'b0);
   endtask

   task automatic randomPhase();
      int tm, vm, len;
      for (int s = 0; s < 25; s++) begin
         tm  = $urandom_range(0, 15);
         vm  = $urandom_range(0, 15);
         len = $urandom_range(40, 250);
         for (int i = 0; i < len; i++) begin
            applyStimulus(tm, vm, $urandom_range(20, 121), $urandom_range(0, 7) == 0);
         end
      end
   endtask

   // monitor: compares every queued prediction against the DUT
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("heater", int'(bus.heater_o), e.heater);
            checkOutput("motor",  int'(bus.motor_o),  e.motor);
            checkOutput("state",  int'(bus.state_o),  e.state);
            checkOutput("fault",  int'(bus.fault_o),  e.fault);
         end
      end
   end

   initial begin
      int h;
      int samples[5];
      int heats[5];
      samples = '{47, 48, 49, 50, 48};
      heats   = '{0, 1, 1, 0, 1};
      bus.tempMode_i   = 4'd0;
      bus.velMode_i    = 4'd0;
      bus.temp_i       = 8'd0;
      bus.temp_valid_i = 1'b0;
      modelReset();

      // power-on reset takes effect without a clock edge
      #1 rst_i = 1'b1;
      #1;
      checkOutput("porHeater", int'(bus.heater_o), 0);
      checkOutput("porMotor",  int'(bus.motor_o),  0);
      checkOutput("porState",  int'(bus.state_o),  0);
      checkOutput("porFault",  int'(bus.fault_o),  0);
      repeat (2) @(posedge clk_i);
      releaseReset();
      runCycles(20, 0, 0, 25, 10, h);

      // thermostat, setpoint 50; first sample arrives while still IDLE
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3, 0, samples[i], 1'b1);
         @(posedge clk_i);
         #2;
         checkOutput($sformatf("thermo%0d", i), int'(bus.heater_o), heats[i]);
         runCycles(3, 3, 0, samples[i], 0, h);
      end

      // asynchronous reset in the middle of a run with the heater on
      runCycles(400, 3, 5, 45, 50, h);
      checkOutput("preRstHeater", int'(bus.heater_o), 1);
      checkOutput("preRstState",  int'(bus.state_o),  S_RUN);
      rst_i = 1'b1;
      #1;
      checkOutput("rstHeater", int'(bus.heater_o), 0);
      checkOutput("rstMotor",  int'(bus.motor_o),  0);
      checkOutput("rstState",  int'(bus.state_o),  0);
      checkOutput("rstFault",  int'(bus.fault_o),  0);
      repeat (2) @(posedge clk_i);
      releaseReset();
      runCycles(20, 0, 0, 30, 10, h);

      // soft start to duty 140, then soft stop
      runCycles(600, 0, 5, 30, 50, h);
      runCycles(256, 0, 5, 30, 0, h);
      checkOutput("pwmHigh140", h, 140);
      runCycles(10, 0, 0, 30, 0, h);
      checkOutput("stopState", int'(bus.state_o), S_STOP);
      runCycles(700, 0, 0, 30, 50, h);
      checkOutput("stopToIdle", int'(bus.state_o), S_IDLE);

      // over-temperature
      runCycles(300, 5, 9, 50, 50, h);
      checkOutput("otHeaterOn", int'(bus.heater_o), 1);
      applyStimulus(5, 9, 120, 1'b1);
      @(posedge clk_i);
      #2;
      checkOutput("otFault",  int'(bus.fault_o),  1);
      checkOutput("otHeater", int'(bus.heater_o), 0);
      runCycles(200, 5, 9, 110, 50, h);
      checkOutput("otHoldFault", int'(bus.state_o), S_FAULT);
      runCycles(1000, 0, 0, 100, 20, h);
      checkOutput("otRecover", int'(bus.state_o), S_IDLE);

      // watchdog boundary: pulse on clock 1000 survives, silence does not
      runCycles(50, 0, 2, 30, 10, h);
      runCycles(999, 0, 2, 30, 0, h);
      applyStimulus(0, 2, 30, 1'b1);
      @(posedge clk_i);
      #2;
      checkOutput("wdPulseAtLimit", int'(bus.fault_o), 0);
      runCycles(999, 0, 2, 30, 0, h);
      checkOutput("wdBeforeLimit", int'(bus.fault_o), 0);
      runCycles(1, 0, 2, 30, 0, h);
      checkOutput("wdExpire", int'(bus.fault_o), WD_ON);
      runCycles(400, 0, 0, 30, 20, h);
      checkOutput("wdRecover", int'(bus.state_o), S_IDLE);

      // mode clamping and fault priority over STOP
      runCycles(1100, 12, 15, 60, 50, h);
      runCycles(256, 12, 15, 60, 0, h);
      checkOutput("pwmHigh252", h, 252);
      applyStimulus(0, 0, 125, 1'b1);
      @(posedge clk_i);
      #2;
      checkOutput("faultPriority", int'(bus.state_o), S_FAULT);
      runCycles(1200, 0, 0, 100, 20, h);
      checkOutput("clampRecover", int'(bus.state_o), S_IDLE);

      randomPhase();
      @(posedge clk_i);
      #3;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
